// File: rtl/dvbs2_ts_pkt_serializer_pkg.sv
// Shared definitions for the DVB-S2 TS packet serializer.
//   PKTIN_* : bit positions inside the 6-bit pktIn sample bus
//   TS_SYNC_BYTE / TS_PKT_BITS : MPEG-TS framing constants
//   ser_state_t : serializer frame FSM states
package dvbs2_pkg;
  localparam int PKTIN_BIT    = 0;
  localparam int PKTIN_START  = 1;
  localparam int PKTIN_END    = 2;
  localparam int PKTIN_VALID  = 3;
  localparam int PKTIN_FSTART = 4;
  localparam int PKTIN_FEND   = 5;

  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
  localparam int         TS_PKT_BITS  = 1504;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_FRAME,
    ST_RUN
  } ser_state_t;
endpackage

// File: rtl/dvbs2_ts_pkt_serializer_if.sv
// Valid/ready TS byte stream into the serializer.
//   s_data  : TS byte
//   s_valid : s_data valid
//   s_sop   : first byte of a TS packet (qualified by s_valid)
//   s_ready : byte taken when s_valid & s_ready
// master = byte source (DDR read FIFO side), slave = serializer.
interface dvbs2_ts_pkt_serializer_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_sop;
  logic       s_ready;

  modport master (output s_data, s_valid, s_sop, input s_ready);
  modport slave  (input s_data, s_valid, s_sop, output s_ready);
endinterface

// File: rtl/dvbs2_ts_pkt_serializer_shifter.sv
// dvbs2_byte_shifter: 8-bit load/shift register, MSB first.
//   clk, reset : clock, async active-high reset
//   load, din  : load a new byte (takes priority over shifting)
//   bit_out    : bit currently presented (0 when empty)
//   empty      : no byte held
//   first/last : presenting bit 0 (MSB) / bit 7 (LSB) of the held byte
// Once loaded it shifts every cycle; after the LSB it empties unless
// reloaded in the same cycle, which gives bubble-free back-to-back bytes.
module dvbs2_byte_shifter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] din,
  output logic       bit_out,
  output logic       empty,
  output logic       first,
  output logic       last
);
  logic [7:0] sr;
  logic       full;
  logic [2:0] bit_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr      <= '0;
      full    <= 1'b0;
      bit_cnt <= '0;
    end else if (load) begin
      sr      <= din;
      full    <= 1'b1;
      bit_cnt <= '0;
    end else if (full) begin
      if (bit_cnt == 3'd7) begin
        sr      <= '0;   // keeps bit_out low on empty cycles
        full    <= 1'b0;
        bit_cnt <= '0;
      end else begin
        sr      <= {sr[6:0], 1'b0};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  assign bit_out = sr[7];
  assign empty   = !full;
  assign first   = full && (bit_cnt == 3'd0);
  assign last    = full && (bit_cnt == 3'd7);
endmodule

// File: rtl/dvbs2_ts_pkt_serializer.sv
// dvbs2_ts_pkt_serializer: turns a TS byte stream into bit-per-cycle
// pktIn samples for the DVB-S2 transmitter, one baseband frame
// (PKTS_PER_FRAME packets) per nextFrame request.
//   clk, reset   : clock, async active-high reset
//   s            : TS byte stream (slave modport)
//   nextFrame    : transmitter ready for a new frame (level)
//   pktIn[5:0]   : {frameEnd, frameStart, valid, pktEnd, pktStart, bit}
//   frame_busy   : frame in progress
//   sync_err_cnt : discarded packets, saturating
// Optional macro DVBS2_SER_SYNC_CHECK_EN: packets whose s_sop byte is not
// 0x47 are accepted and discarded up to the next s_sop.
module dvbs2_ts_pkt_serializer
  import dvbs2_pkg::*;
#(
  parameter int PKT_BYTES      = 188,
  parameter int PKTS_PER_FRAME = 21
) (
  input  logic                       clk,
  input  logic                       reset,
  dvbs2_ts_pkt_serializer_if.slave   s,
  input  logic                       nextFrame,
  output logic [5:0]                 pktIn,
  output logic                       frame_busy,
  output logic [15:0]                sync_err_cnt
);
  localparam int BW = $clog2(PKT_BYTES);
  localparam int PW = $clog2(PKTS_PER_FRAME);
  localparam logic [BW-1:0] BYTE_LAST = BW'(PKT_BYTES - 1);
  localparam logic [PW-1:0] PKT_LAST  = PW'(PKTS_PER_FRAME - 1);

  ser_state_t    state;
  logic [BW-1:0] byte_cnt;   // packet position of the next byte to load
  logic [PW-1:0] pkt_cnt;    // packet index of the next byte to load
  // position attributes of the byte currently in the shifter
  logic          cur_first, cur_end, cur_fpkt, cur_lpkt;

  logic          sh_bit, sh_empty, sh_first, sh_last;
  logic          frame_last, accept, load, sync_bad, sop_err;
  logic [BW-1:0] pos;

  dvbs2_byte_shifter u_shifter (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .din     (s.s_data),
    .bit_out (sh_bit),
    .empty   (sh_empty),
    .first   (sh_first),
    .last    (sh_last)
  );

  assign frame_last = sh_last && cur_end && cur_lpkt;

  // Refill on empty or on the LSB cycle, except on the frame's final bit:
  // a byte taken then would have nowhere to go once we drop to WAIT_FRAME.
  assign s.s_ready = (state == ST_RUN) &&
                     (sh_empty || (sh_last && !(cur_end && cur_lpkt)));
  assign accept    = s.s_valid && s.s_ready;

`ifdef DVBS2_SER_SYNC_CHECK_EN
  logic drop;  // discarding the rest of a bad-sync packet

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  drop <= 1'b0;
    else if (accept && s.s_sop) drop <= sync_bad;
  end

  assign sync_bad = s.s_sop && (s.s_data != TS_SYNC_BYTE);
  assign load     = accept && !sync_bad && (s.s_sop || !drop);
`else
  assign sync_bad = 1'b0;
  assign load     = accept;
`endif

  // Misplaced s_sop restarts the packet at byte 0 within the same pkt slot.
  assign sop_err = load && s.s_sop && (byte_cnt != '0);
  assign pos     = sop_err ? '0 : byte_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      byte_cnt     <= '0;
      pkt_cnt      <= '0;
      cur_first    <= 1'b0;
      cur_end      <= 1'b0;
      cur_fpkt     <= 1'b0;
      cur_lpkt     <= 1'b0;
      sync_err_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE:       state <= ST_WAIT_FRAME;
        ST_WAIT_FRAME: if (nextFrame)  state <= ST_RUN;
        ST_RUN:        if (frame_last) state <= ST_WAIT_FRAME;
        default:       state <= ST_IDLE;
      endcase

      if ((sop_err || (accept && sync_bad)) && (sync_err_cnt != '1))
        sync_err_cnt <= sync_err_cnt + 16'd1;

      if (accept && sync_bad) byte_cnt <= '0;

      if (load) begin
        cur_first <= (pos == '0);
        cur_end   <= (pos == BYTE_LAST);
        cur_fpkt  <= (pkt_cnt == '0);
        cur_lpkt  <= (pkt_cnt == PKT_LAST);
        if (pos == BYTE_LAST) begin
          byte_cnt <= '0;
          pkt_cnt  <= (pkt_cnt == PKT_LAST) ? '0 : pkt_cnt + 1'b1;
        end else begin
          byte_cnt <= pos + 1'b1;
        end
      end
    end
  end

  always_comb begin
    pktIn = '0;
    if (!sh_empty) begin
      pktIn[PKTIN_BIT]    = sh_bit;
      pktIn[PKTIN_VALID]  = 1'b1;
      pktIn[PKTIN_START]  = sh_first && cur_first;
      pktIn[PKTIN_END]    = sh_last && cur_end;
      pktIn[PKTIN_FSTART] = sh_first && cur_first && cur_fpkt;
      pktIn[PKTIN_FEND]   = frame_last;
    end
  end

  assign frame_busy = (state == ST_RUN);
endmodule

// File: tb/tb_dvbs2_ts_pkt_serializer.sv
module tb_dvbs2_ts_pkt_serializer;
  import dvbs2_pkg::*;

  localparam int PB = 188;
  localparam int PF = 21;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        nextFrame = 1'b0;
  logic [5:0]  pktIn;
  logic        frame_busy;
  logic [15:0] sync_err_cnt;

  dvbs2_ts_pkt_serializer_if s_if ();

  dvbs2_ts_pkt_serializer dut (
    .clk          (clk),
    .reset        (reset),
    .s            (s_if.slave),
    .nextFrame    (nextFrame),
    .pktIn        (pktIn),
    .frame_busy   (frame_busy),
    .sync_err_cnt (sync_err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic sop; logic [7:0] data; } src_byte_t;
  src_byte_t  src_q[$];
  logic [5:0] exp_q[$];

  int total = 0;
  int bad   = 0;

  // run_frame results
  int r_mism, r_fidx, r_nval, r_maxrun, r_nstart, r_nend, r_spacing_bad;
  int r_first_acc, r_first_val, r_last_val, r_busy_fall, r_gaps;
  logic [5:0] r_fobs, r_fexp;
  logic [7:0] r_first8;
  logic r_rdy0, r_busy0, r_timeout;
  int start_cyc, exp_n, m_errs, q_rdy, q_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stream(input string tag);
    total++;
    assert (r_mism === 0) else begin
      bad++;
      $error("FAIL %s mismatches=%0d first at sample %0d obs=%b exp=%b",
             tag, r_mism, r_fidx, r_fobs, r_fexp);
    end
  endtask

  task automatic add_pkt(input int len, input logic [7:0] first);
    src_byte_t b;
    for (int i = 0; i < len; i++) begin
      b.sop  = (i == 0);
      b.data = (i == 0) ? first : 8'($urandom);
      src_q.push_back(b);
    end
  endtask

  // Reference: walk the offered bytes, track packet/frame position by the
  // stream rules and list every valid sample of one frame.
  task automatic model_frame(output int errs);
    int pos, pkt;
    bit drop;
    src_byte_t b;
    logic [5:0] smp;
    pos = 0; pkt = 0; drop = 0; errs = 0;
    foreach (src_q[i]) begin
      b = src_q[i];
`ifdef DVBS2_SER_SYNC_CHECK_EN
      if (b.sop) begin
        if (b.data != TS_SYNC_BYTE) begin drop = 1; errs++; pos = 0; continue; end
        drop = 0;
      end else if (drop) continue;
`endif
      if (b.sop && pos != 0) begin errs++; pos = 0; end
      for (int k = 0; k < 8; k++) begin
        smp = '0;
        smp[PKTIN_BIT]    = b.data[7-k];
        smp[PKTIN_VALID]  = 1'b1;
        smp[PKTIN_START]  = (pos == 0 && k == 0);
        smp[PKTIN_END]    = (pos == PB-1 && k == 7);
        smp[PKTIN_FSTART] = (pos == 0 && k == 0 && pkt == 0);
        smp[PKTIN_FEND]   = (pos == PB-1 && k == 7 && pkt == PF-1);
        exp_q.push_back(smp);
      end
      pos++;
      if (pos == PB) begin
        pos = 0; pkt++;
        if (pkt == PF) break;
      end
    end
  endtask

  task automatic start_frame();
    @(negedge clk);
    chk("wait_ready", s_if.s_ready, 0);
    nextFrame = 1'b1;
    start_cyc = cyc;
  endtask

  // Per cycle at negedge: score this cycle's pktIn, then drive the source.
  // The first gap_bytes accepted bytes are offered only every third cycle.
  task automatic run_frame(input int gap_bytes, input int stop_after);
    int acc, budget, run, prev_start;
    logic [5:0] e;
    acc = 0; budget = 0; run = 0; prev_start = -1;
    r_mism = 0; r_fidx = -1; r_nval = 0; r_maxrun = 0; r_nstart = 0; r_nend = 0;
    r_spacing_bad = 0; r_first_acc = -1; r_first_val = -1; r_last_val = -1;
    r_busy_fall = -1; r_gaps = 0; r_first8 = '0; r_timeout = 1'b1;
    r_fobs = '0; r_fexp = '0;
    while (budget < 60000) begin
      @(negedge clk);
      if (budget == 0) begin
        r_rdy0 = s_if.s_ready; r_busy0 = frame_busy; nextFrame = 1'b0;
      end
      budget++;
      if (pktIn[PKTIN_VALID] === 1'b1) begin
        if (r_first_val < 0) r_first_val = cyc;
        r_last_val = cyc;
        r_nval++;
        run++;
        if (run > r_maxrun) r_maxrun = run;
        if (r_nval <= 8) r_first8 = {r_first8[6:0], pktIn[PKTIN_BIT]};
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 6'd0;
        if (pktIn !== e) begin
          if (r_mism == 0) begin r_fobs = pktIn; r_fexp = e; r_fidx = r_nval; end
          r_mism++;
        end
        if (pktIn[PKTIN_START]) begin
          if (prev_start >= 0 && cyc - prev_start != PB*8) r_spacing_bad++;
          prev_start = cyc;
          r_nstart++;
        end
        if (pktIn[PKTIN_END]) r_nend++;
      end else begin
        run = 0;
        if (r_first_val >= 0 && frame_busy) r_gaps++;
        if (pktIn !== 6'd0) begin
          if (r_mism == 0) begin r_fobs = pktIn; r_fexp = 6'd0; r_fidx = r_nval; end
          r_mism++;
        end
      end
      if (stop_after > 0 && r_nval == stop_after) begin r_timeout = 1'b0; break; end
      if (r_nval > 0 && !frame_busy && exp_q.size() == 0) begin
        r_busy_fall = cyc; r_timeout = 1'b0; break;
      end
      if (src_q.size() > 0 && (acc >= gap_bytes || cyc % 3 == 0)) begin
        s_if.s_valid = 1'b1;
        {s_if.s_sop, s_if.s_data} = src_q[0];
      end else begin
        s_if.s_valid = 1'b0; s_if.s_sop = 1'b0;
      end
      if (s_if.s_valid && s_if.s_ready) begin
        void'(src_q.pop_front());
        if (r_first_acc < 0) r_first_acc = cyc;
        acc++;
      end
    end
  endtask

  initial begin
    s_if.s_valid = 1'b0; s_if.s_sop = 1'b0; s_if.s_data = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_pktIn", pktIn, 0);
    chk("rst_ready", s_if.s_ready, 0);
    chk("rst_busy", frame_busy, 0);
    chk("rst_errcnt", sync_err_cnt, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_ready", s_if.s_ready, 0);
    chk("idle_busy", frame_busy, 0);

    // frame 1: continuous stream of 21 good packets
    for (int p = 0; p < PF; p++) add_pkt(PB, TS_SYNC_BYTE);
    model_frame(m_errs);
    exp_n = exp_q.size();
    start_frame();
    run_frame(0, 0);
    chk("f1_timeout", r_timeout, 0);
    chk("f1_ready_n1", r_rdy0, 1);
    chk("f1_busy_n1", r_busy0, 1);
    chk("f1_accept_cyc", r_first_acc, start_cyc + 1);
    chk("f1_first_out", r_first_val, r_first_acc + 1);
    chk_stream("f1_stream");
    chk("f1_nval", r_nval, exp_n);
    chk("f1_consec", r_maxrun, PF*PB*8);
    chk("f1_first8", r_first8, 8'h47);
    chk("f1_nstart", r_nstart, PF);
    chk("f1_nend", r_nend, PF);
    chk("f1_spacing", r_spacing_bad, 0);
    chk("f1_busy_fall", r_busy_fall, r_last_val + 1);
    chk("f1_errcnt", sync_err_cnt, m_errs);

    // frame 2 stimulus offered while nextFrame stays low
`ifdef DVBS2_SER_SYNC_CHECK_EN
    add_pkt(PB, 8'h46);
`endif
    add_pkt(PB, TS_SYNC_BYTE);
    add_pkt(PB, TS_SYNC_BYTE);
    add_pkt(100, TS_SYNC_BYTE);   // next s_sop lands on byte 100
    for (int p = 0; p < PF-2; p++) add_pkt(PB, TS_SYNC_BYTE);
    model_frame(m_errs);
    exp_n = exp_q.size();
    q_rdy = 0; q_out = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      s_if.s_valid = 1'b1;
      {s_if.s_sop, s_if.s_data} = src_q[0];
      if (s_if.s_ready !== 1'b0) q_rdy++;
      if (pktIn !== 6'd0 || frame_busy !== 1'b0) q_out++;
    end
    chk("hold_ready", q_rdy, 0);
    chk("hold_out", q_out, 0);

    // frame 2: first three packets' worth of bytes offered 1-of-3 cycles
    start_frame();
    run_frame(3*PB, 0);
    chk("f2_timeout", r_timeout, 0);
    chk("f2_ready_n1", r_rdy0, 1);
    chk_stream("f2_stream");
    chk("f2_nval", r_nval, exp_n);
    chk("f2_gaps", r_gaps > 0, 1);
    chk("f2_nstart", r_nstart, PF + 1);
    chk("f2_nend", r_nend, PF);
    chk("f2_errcnt", sync_err_cnt, m_errs);

    // frame 3: async reset at sample 5000
    for (int p = 0; p < PF; p++) add_pkt(PB, TS_SYNC_BYTE);
    model_frame(m_errs);
    start_frame();
    run_frame(0, 5000);
    chk("f3_timeout", r_timeout, 0);
    chk_stream("f3_stream");
    #2 reset = 1'b1;
    #1;
    chk("arst_pktIn", pktIn, 0);
    chk("arst_busy", frame_busy, 0);
    chk("arst_ready", s_if.s_ready, 0);
    chk("arst_errcnt", sync_err_cnt, 0);
    s_if.s_valid = 1'b0; s_if.s_sop = 1'b0;
    src_q.delete(); exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    q_out = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pktIn !== 6'd0 || frame_busy !== 1'b0 || s_if.s_ready !== 1'b0) q_out++;
    end
    chk("post_rst_quiet", q_out, 0);
    start_frame();
    @(negedge clk);
    nextFrame = 1'b0;
    chk("restart_ready", s_if.s_ready, 1);
    s_if.s_valid = 1'b1; s_if.s_sop = 1'b1; s_if.s_data = TS_SYNC_BYTE;
    @(negedge clk);
    s_if.s_valid = 1'b0; s_if.s_sop = 1'b0;
    chk("restart_out", pktIn,
        (32'd1 << PKTIN_VALID) | (32'd1 << PKTIN_START) | (32'd1 << PKTIN_FSTART));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
